// File: rtl/mem_client_reader.sv
// Client-side read initiator: splits a byte-length job into 32-byte line requests (one outstanding),
// buffers returned lines in a small FIFO and streams them out as ready/valid with byte count and last flag.
module mem_client_reader #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 256,
    parameter int LEN_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  num_bytes,
    output logic              busy,
    output logic              done,
    output logic              err_unexp,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_start_addr,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [5:0]        out_bytes,
    output logic              out_last
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int LN_W  = LEN_W - 4;

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_FIN} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [5:0]        bytes;
        logic              last;
    } entry_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LN_W-1:0]   lines_q, lines_d;
    logic [LN_W-1:0]   issued_q, issued_d;
    logic [5:0]        tail_q, tail_d;
    logic              err_q, err_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    entry_t            fifo_q [FIFO_DEPTH];
    entry_t            fifo_d [FIFO_DEPTH];

    logic [LN_W-1:0]   job_lines;
    logic [5:0]        job_tail;
    logic              push, pop, last_push;
    logic [CNT_W-1:0]  cnt_post;
    entry_t            head, push_entry;

    always_comb begin
        job_lines = LN_W'((32'(num_bytes) + 32'd31) >> 5);
        job_tail  = (num_bytes[4:0] == 5'd0) ? 6'd32 : {1'b0, num_bytes[4:0]};

        head      = fifo_q[rd_ptr_q];
        out_valid = (cnt_q != '0);
        pop       = out_valid & out_ready;
        push      = (state_q == S_REQ) & mem_valid;
        last_push = ((issued_q + LN_W'(1)) == lines_q);
        cnt_post  = cnt_q + CNT_W'(push) - CNT_W'(pop);

        push_entry.data  = mem_data;
        push_entry.bytes = last_push ? tail_q : 6'd32;
        push_entry.last  = last_push;
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        lines_d  = lines_q;
        issued_d = issued_q;
        tail_d   = tail_q;
        err_d    = err_q | (mem_valid & (state_q != S_REQ));

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    lines_d  = job_lines;
                    tail_d   = job_tail;
                    issued_d = '0;
                    // An empty job passes through DRAIN so done lands two cycles after start.
                    state_d  = (num_bytes == '0) ? S_DRAIN : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_valid) begin
                    issued_d = issued_q + LN_W'(1);
                    if (last_push) begin
                        state_d = S_DRAIN;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(32);
                        state_d = (cnt_post < CNT_W'(FIFO_DEPTH)) ? S_REQ : S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q < CNT_W'(FIFO_DEPTH)) state_d = S_REQ;
            end
            S_DRAIN: begin
                if ((lines_q == '0) || (pop && head.last)) state_d = S_FIN;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_post;
        if (push) begin
            fifo_d[wr_ptr_q] = push_entry;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            lines_q  <= '0;
            issued_q <= '0;
            tail_q   <= '0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            lines_q  <= lines_d;
            issued_q <= issued_d;
            tail_q   <= tail_d;
            err_q    <= err_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Line storage needs no reset: the stream outputs are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_FIN);
    assign mem_req        = (state_q == S_REQ);
    assign mem_start_addr = addr_q;
    assign err_unexp      = err_q;
    assign out_data       = out_valid ? head.data  : '0;
    assign out_bytes      = out_valid ? head.bytes : '0;
    assign out_last       = out_valid ? head.last  : 1'b0;

endmodule

// File: tb/tb_mem_client_reader.sv
// Randomized bench for mem_client_reader: memory responder, random-ready consumer and a
// job-level reference model (expected line addresses and stream entries) kept in queues.
module tb_mem_client_reader;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 256;
    localparam int LEN_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  num_bytes;
    logic              busy, done, err_unexp, mem_req;
    logic [ADDR_W-1:0] mem_start_addr;
    logic              mem_valid;
    logic [DATA_W-1:0] mem_data;
    logic              out_valid, out_ready, out_last;
    logic [DATA_W-1:0] out_data;
    logic [5:0]        out_bytes;

    mem_client_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_bytes(num_bytes),
        .busy(busy), .done(done), .err_unexp(err_unexp), .mem_req(mem_req),
        .mem_start_addr(mem_start_addr), .mem_valid(mem_valid), .mem_data(mem_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_bytes(out_bytes), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [5:0]        bytes;
        logic              last;
    } line_t;

    int checks = 0;
    int failures = 0;
    line_t             exp_q[$];
    logic [ADDR_W-1:0] exp_addr_q[$];
    int done_cnt = 0;
    int req_cnt = 0;
    int resp_cnt = 0;
    int lat_min = 0;
    int lat_max = 0;
    int ready_mode = 0;   // 0: always ready, 1: never ready, 2: random
    int inj_req = 0;
    int inj_ack = 0;
    logic [31:0] seed = 32'h1234_5678;

    function automatic logic [DATA_W-1:0] line_of(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] d;
        for (int w = 0; w < 8; w++)
            d[w*32 +: 32] = (32'(a) * 32'h9E37_79B1) ^ (32'(w) * 32'h85EB_CA6B) ^ seed;
        return d;
    endfunction

    // Reference: the job's line addresses and stream entries, straight from the byte count.
    task automatic model_job(input logic [ADDR_W-1:0] b, input int len);
        int n;
        line_t l;
        logic [ADDR_W-1:0] a;
        n = (len + 31) / 32;
        for (int i = 0; i < n; i++) begin
            a = ADDR_W'(int'(b) + 32 * i);
            exp_addr_q.push_back(a);
            l.data  = line_of(a);
            l.bytes = (i == n - 1) ? 6'(((len - 1) % 32) + 1) : 6'd32;
            l.last  = (i == n - 1);
            exp_q.push_back(l);
        end
    endtask

    // Memory responder
    initial begin
        int lat_cnt;
        int lat_tgt;
        bit pending;
        lat_cnt = 0; lat_tgt = 0; pending = 0;
        mem_valid = 1'b0;
        mem_data  = '0;
        forever begin
            @(posedge clk); #1;
            mem_valid = 1'b0;
            if (rst) begin
                pending = 0;
            end else if (inj_req != inj_ack) begin
                mem_valid = 1'b1;
                mem_data  = '1;
                inj_ack   = inj_req;
            end else if (mem_req) begin
                if (!pending) begin
                    pending = 1;
                    lat_cnt = 0;
                    lat_tgt = $urandom_range(lat_min, lat_max);
                end
                if (lat_cnt >= lat_tgt) begin
                    checks++;
                    if (exp_addr_q.size() == 0) begin
                        failures++;
                        $display("FAIL req_addr: unexpected request at %h, none expected", mem_start_addr);
                    end else begin
                        logic [ADDR_W-1:0] ea;
                        ea = exp_addr_q.pop_front();
                        if (mem_start_addr !== ea) begin
                            failures++;
                            $display("FAIL req_addr: got %h expected %h", mem_start_addr, ea);
                        end
                    end
                    mem_valid = 1'b1;
                    mem_data  = line_of(mem_start_addr);
                    resp_cnt++;
                    pending = 0;
                end else begin
                    lat_cnt++;
                end
            end else if (pending) begin
                checks++;
                failures++;
                $display("FAIL req_hold: mem_req dropped before response");
                pending = 0;
            end
        end
    end

    // Consumer ready driver
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Stream monitor: pops against the model, stall stability, done accounting
    initial begin
        bit hold;
        logic [DATA_W-1:0] h_data;
        logic [5:0] h_bytes;
        logic h_last;
        line_t e;
        hold = 0; h_data = '0; h_bytes = '0; h_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 0;
            end else begin
                if (hold) begin
                    checks++;
                    if (!out_valid || out_data !== h_data || out_bytes !== h_bytes || out_last !== h_last) begin
                        failures++;
                        $display("FAIL stall_stable: got v=%b bytes=%0d last=%b expected v=1 bytes=%0d last=%b",
                                 out_valid, out_bytes, out_last, h_bytes, h_last);
                    end
                end
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL stream: unexpected line bytes=%0d", out_bytes);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_data !== e.data || out_bytes !== e.bytes || out_last !== e.last) begin
                            failures++;
                            $display("FAIL stream: got bytes=%0d last=%b data=%h expected bytes=%0d last=%b data=%h",
                                     out_bytes, out_last, out_data, e.bytes, e.last, e.data);
                        end
                    end
                end
                hold    = out_valid && !out_ready;
                h_data  = out_data;
                h_bytes = out_bytes;
                h_last  = out_last;
                if (done) begin
                    done_cnt++;
                    checks++;
                    if (exp_q.size() != 0) begin
                        failures++;
                        $display("FAIL done_early: got %0d lines outstanding expected 0", exp_q.size());
                    end
                end
                if (mem_req) req_cnt++;
            end
        end
    end

    task automatic start_job(input logic [ADDR_W-1:0] b, input int len);
        @(posedge clk); #1;
        model_job(b, len);
        base_addr = b;
        num_bytes = LEN_W'(len);
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_job(input string name, input int budget);
        int d0;
        int k;
        d0 = done_cnt;
        k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (done_cnt == d0) begin
            failures++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (done_cnt != d0 + 1 || exp_q.size() != 0 || exp_addr_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_end: got dones=%0d lines_left=%0d reqs_left=%0d busy=%b expected 1 0 0 0",
                     name, done_cnt - d0, exp_q.size(), exp_addr_q.size(), busy);
        end
        exp_q.delete();
        exp_addr_q.delete();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, err_unexp, mem_req, out_valid, out_last} !== 6'b0 || mem_start_addr !== '0 ||
            out_data !== '0 || out_bytes !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b req=%b addr=%h ov=%b expected all 0",
                     busy, done, err_unexp, mem_req, mem_start_addr, out_valid);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, err_unexp, mem_req, out_valid} !== 5'b0) begin
            failures++;
            $display("FAIL reset_idle: got busy=%b done=%b err=%b req=%b ov=%b expected all 0",
                     busy, done, err_unexp, mem_req, out_valid);
        end
    endtask

    task automatic test_basic();
        int r0;
        seed = $urandom;
        lat_min = 3; lat_max = 3; ready_mode = 0;
        r0 = resp_cnt;
        start_job(19'h00100, 64);
        wait_job("basic", 200);
        checks++;
        if (resp_cnt - r0 != 2) begin
            failures++;
            $display("FAIL basic_reqs: got %0d expected 2", resp_cnt - r0);
        end
    endtask

    task automatic test_wrap();
        int r0;
        seed = $urandom;
        lat_min = 0; lat_max = 2; ready_mode = 2;
        r0 = resp_cnt;
        start_job(19'h7FFE0, 70);
        wait_job("wrap", 300);
        checks++;
        if (resp_cnt - r0 != 3) begin
            failures++;
            $display("FAIL wrap_reqs: got %0d expected 3", resp_cnt - r0);
        end
    endtask

    task automatic test_backpressure();
        int r0;
        logic [ADDR_W-1:0] b;
        seed = $urandom;
        lat_min = 0; lat_max = 0; ready_mode = 1;
        r0 = resp_cnt;
        b = ADDR_W'($urandom) & ~ADDR_W'(31);
        start_job(b, 256);
        repeat (20) @(negedge clk);
        checks++;
        if (resp_cnt - r0 != 4 || mem_req !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL bp_wait: got lines=%0d req=%b busy=%b ov=%b expected 4 0 1 1",
                     resp_cnt - r0, mem_req, busy, out_valid);
        end
        ready_mode = 0;
        wait_job("bp", 300);
        checks++;
        if (resp_cnt - r0 != 8) begin
            failures++;
            $display("FAIL bp_total: got %0d expected 8", resp_cnt - r0);
        end
    endtask

    task automatic test_empty_job();
        int q0;
        int d0;
        q0 = req_cnt;
        d0 = done_cnt;
        @(posedge clk); #1;
        base_addr = 19'h00040;
        num_bytes = '0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL empty_t1: got busy=%b done=%b expected 1 0", busy, done);
        end
        @(posedge clk); #1;
        base_addr = 19'h00200;
        num_bytes = LEN_W'(64);
        start = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done !== 1'b1) begin
            failures++;
            $display("FAIL empty_t2: got busy=%b done=%b expected 1 1", busy, done);
        end
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL empty_t3: got busy=%b done=%b expected 0 0", busy, done);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (done_cnt - d0 != 1 || req_cnt != q0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL empty_after: got dones=%0d req_cycles=%0d ov=%b expected 1 0 0",
                     done_cnt - d0, req_cnt - q0, out_valid);
        end
    endtask

    task automatic test_err_and_reset();
        int r0;
        int k;
        @(negedge clk);
        inj_req++;
        repeat (4) @(negedge clk);
        checks++;
        if (err_unexp !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL err_set: got err=%b ov=%b busy=%b expected 1 0 0", err_unexp, out_valid, busy);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (err_unexp !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky: got %b expected 1", err_unexp);
        end
        seed = $urandom;
        lat_min = 0; lat_max = 0; ready_mode = 1;
        r0 = resp_cnt;
        start_job(19'h01000, 256);
        k = 0;
        while (resp_cnt - r0 < 3 && k < 50) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (resp_cnt - r0 < 3 || mem_req !== 1'b1) begin
            failures++;
            $display("FAIL midjob_setup: got responses=%0d req=%b expected 3 1", resp_cnt - r0, mem_req);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, err_unexp, mem_req, out_valid, out_last} !== 6'b0 || mem_start_addr !== '0 ||
            out_data !== '0 || out_bytes !== '0) begin
            failures++;
            $display("FAIL midjob_reset: got busy=%b done=%b err=%b req=%b addr=%h ov=%b expected all 0",
                     busy, done, err_unexp, mem_req, mem_start_addr, out_valid);
        end
        exp_q.delete();
        exp_addr_q.delete();
        @(negedge clk);
        rst = 1'b0;
        seed = $urandom;
        ready_mode = 2; lat_max = 1;
        start_job(19'h03F80, 100);
        wait_job("post_reset", 300);
    endtask

    task automatic test_random();
        int lens[4] = '{1, 32, 33, 160};
        int len;
        logic [ADDR_W-1:0] b;
        for (int j = 0; j < 8; j++) begin
            seed = $urandom;
            lat_min = 0;
            lat_max = $urandom_range(0, 3);
            ready_mode = 2;
            len = (j < 4) ? lens[j] : $urandom_range(1, 300);
            b = ADDR_W'($urandom);
            start_job(b, len);
            wait_job("random", 2000);
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        base_addr = '0;
        num_bytes = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_empty_job();
        test_err_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
